mem_stage_ctrl: RTL and testbench

//   Memory-stage sequencer between the EX/MEM pipeline register and the data-memory

---
 rtl/mem_stage_if.sv | 33 +++
 rtl/mem_stage_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus bundle between the EX/MEM register, mem_stage_ctrl and the data-memory controller.
// master = pipeline/memory environment side, slave = the mem_stage_ctrl sequencer.
interface mem_stage_if;
    logic        req_valid;
    logic        req_mem_w;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dm_ctrl;
    logic        dm_en;
    logic        dm_mem_w;
    logic [31:0] dm_addr;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        done;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        access_fault;
    logic [31:0] fault_addr;

    modport master (
        output req_valid, req_mem_w, req_addr, req_wdata, req_dm_ctrl, dm_rdata,
        input  dm_en, dm_mem_w, dm_addr, dm_ctrl, dm_wdata,
        input  stall, done, wb_valid, wb_rdata, access_fault, fault_addr
    );

    modport slave (
        input  req_valid, req_mem_w, req_addr, req_wdata, req_dm_ctrl, dm_rdata,
        output dm_en, dm_mem_w, dm_addr, dm_ctrl, dm_wdata,
        output stall, done, wb_valid, wb_rdata, access_fault, fault_addr
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: runs one load/store at a time against a byte-enabled BRAM and
// rejects faulting requests. Define MEM_STAGE_PERF_EN to add load/store/stall counters.
module mem_stage_ctrl #(
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned DM_ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall_cyc
`endif
);
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned RANGE_LSB = DM_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             stall_c;
    logic             misalign_c;
    logic             out_of_range_c;
    logic             bad_ctrl_c;
    logic             fault_c;

    assign stall_c   = bus.req_valid & ~bus.done;
    assign bus.stall = stall_c;

    // Request screening, consumed only when a request is accepted in IDLE.
    always_comb begin
        misalign_c = 1'b0;
        case (bus.req_dm_ctrl)
            3'b000:         misalign_c = (bus.req_addr[1:0] != 2'b00);
            3'b001, 3'b010: misalign_c = bus.req_addr[0];
            default:        misalign_c = 1'b0;
        endcase
    end

    assign out_of_range_c = ((bus.req_addr >> RANGE_LSB) != 32'd0);
    assign bad_ctrl_c     = (bus.req_dm_ctrl > 3'd4);
    assign fault_c        = misalign_c | out_of_range_c | bad_ctrl_c;

    // Sequencer; dm_addr/dm_ctrl stay put after ACCESS because the controller's
    // byte/half select on the read data still depends on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.dm_en        <= 1'b0;
            bus.dm_mem_w     <= 1'b0;
            bus.dm_addr      <= '0;
            bus.dm_ctrl      <= '0;
            bus.dm_wdata     <= '0;
            bus.done         <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_rdata     <= '0;
            bus.access_fault <= 1'b0;
            bus.fault_addr   <= '0;
        end else begin
            bus.dm_en        <= 1'b0;
            bus.dm_mem_w     <= 1'b0;
            bus.done         <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.dm_addr  <= bus.req_addr;
                        bus.dm_ctrl  <= bus.req_dm_ctrl;
                        bus.dm_wdata <= bus.req_wdata;
                        if (fault_c) begin
                            bus.done         <= 1'b1;
                            bus.access_fault <= 1'b1;
                            bus.fault_addr   <= bus.req_addr;
                            state            <= RESP;
                        end else begin
                            bus.dm_en    <= 1'b1;
                            bus.dm_mem_w <= bus.req_mem_w;
                            state        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // dm_mem_w carries the latched direction during this cycle
                    if (bus.dm_mem_w) begin
                        bus.done <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt   <= CNT_W'(READ_LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bus.wb_rdata <= bus.dm_rdata;
                        bus.done     <= 1'b1;
                        bus.wb_valid <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STAGE_PERF_EN
    // Counters bump on the same edge that raises wb_valid / store done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads     <= '0;
            perf_stores    <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (state == WAIT && cnt == '0) perf_loads <= perf_loads + 32'd1;
            if (state == ACCESS && bus.dm_mem_w) perf_stores <= perf_stores + 32'd1;
            if (stall_c) perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed loads, stores and faults on a READ_LATENCY=1 and a
// READ_LATENCY=3 instance, compared every cycle against a transaction-level model.
module tb_mem_stage_ctrl;
    typedef struct packed {
        logic        dm_en;
        logic        dm_mem_w;
        logic [31:0] dm_addr;
        logic [2:0]  dm_ctrl;
        logic [31:0] dm_wdata;
        logic        stall;
        logic        done;
        logic        wb_valid;
        logic [31:0] wb_rdata;
        logic        access_fault;
        logic [31:0] fault_addr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid   [2];
    logic        req_mem_w   [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic [2:0]  req_dm_ctrl [2];
    logic [31:0] rdata_val   [2];
    logic [31:0] pipe0 [4];
    logic [31:0] pipe1 [4];
    obs_t        obs [2];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          checking = 1'b0;

    // model state: one outstanding transaction per instance, k = edges since accept
    bit          m_act   [2];
    int          m_k     [2];
    int          m_lat   [2];
    bit          m_fault [2];
    bit          m_store [2];
    logic [31:0] m_rval  [2];
    logic [31:0] e_addr  [2];
    logic [2:0]  e_ctrl  [2];
    logic [31:0] e_wdata [2];
    logic [31:0] e_wb    [2];
    logic [31:0] e_fa    [2];

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_loads0, perf_stores0, perf_stall0;
    logic [31:0] perf_loads1, perf_stores1, perf_stall1;
    logic [31:0] pm_loads [2];
    logic [31:0] pm_stores [2];
    logic [31:0] pm_stall [2];
`endif

    mem_stage_if bus0 ();
    mem_stage_if bus1 ();

    assign bus0.req_valid   = req_valid[0];
    assign bus0.req_mem_w   = req_mem_w[0];
    assign bus0.req_addr    = req_addr[0];
    assign bus0.req_wdata   = req_wdata[0];
    assign bus0.req_dm_ctrl = req_dm_ctrl[0];
    assign bus0.dm_rdata    = pipe0[0];
    assign bus1.req_valid   = req_valid[1];
    assign bus1.req_mem_w   = req_mem_w[1];
    assign bus1.req_addr    = req_addr[1];
    assign bus1.req_wdata   = req_wdata[1];
    assign bus1.req_dm_ctrl = req_dm_ctrl[1];
    assign bus1.dm_rdata    = pipe1[2];

    assign obs[0] = {bus0.dm_en, bus0.dm_mem_w, bus0.dm_addr, bus0.dm_ctrl, bus0.dm_wdata,
                     bus0.stall, bus0.done, bus0.wb_valid, bus0.wb_rdata,
                     bus0.access_fault, bus0.fault_addr};
    assign obs[1] = {bus1.dm_en, bus1.dm_mem_w, bus1.dm_addr, bus1.dm_ctrl, bus1.dm_wdata,
                     bus1.stall, bus1.done, bus1.wb_valid, bus1.wb_rdata,
                     bus1.access_fault, bus1.fault_addr};

    mem_stage_ctrl #(.READ_LATENCY(1), .DM_ADDR_WIDTH(12)) u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus0)
`ifdef MEM_STAGE_PERF_EN
        ,
        .perf_loads     (perf_loads0),
        .perf_stores    (perf_stores0),
        .perf_stall_cyc (perf_stall0)
`endif
    );

    mem_stage_ctrl #(.READ_LATENCY(3), .DM_ADDR_WIDTH(12)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus1)
`ifdef MEM_STAGE_PERF_EN
        ,
        .perf_loads     (perf_loads1),
        .perf_stores    (perf_stores1),
        .perf_stall_cyc (perf_stall1)
`endif
    );

    always #5 clk = ~clk;

    // BRAM stand-in: returns rdata_val READ_LATENCY edges after a read, junk otherwise
    always @(posedge clk) begin
        pipe0[0] <= (obs[0].dm_en && !obs[0].dm_mem_w) ? rdata_val[0] : 32'hBAD0_BAD0;
        pipe1[0] <= (obs[1].dm_en && !obs[1].dm_mem_w) ? rdata_val[1] : 32'hBAD1_BAD1;
        for (int i = 1; i < 4; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end

    function automatic int rl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit is_fault(input logic [31:0] a, input logic [2:0] c);
        int unsigned size;
        if (c > 3'd4) return 1'b1;
        if (a >= 32'h0000_4000) return 1'b1;
        size = (c == 3'd0) ? 4 : ((c <= 3'd2) ? 2 : 1);
        return (a % size) != 0;
    endfunction

    function automatic bit m_done(input int d);
        return m_act[d] && (m_k[d] == m_lat[d] - 1);
    endfunction

    // Transaction-level model: accept when free, busy for the documented latency
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0; m_k[d] = 0; m_lat[d] = 1;
                m_fault[d] = 1'b0; m_store[d] = 1'b0; m_rval[d] = '0;
                e_addr[d] = '0; e_ctrl[d] = '0; e_wdata[d] = '0; e_wb[d] = '0; e_fa[d] = '0;
`ifdef MEM_STAGE_PERF_EN
                pm_loads[d] = '0; pm_stores[d] = '0; pm_stall[d] = '0;
`endif
            end else begin
`ifdef MEM_STAGE_PERF_EN
                if (req_valid[d] && !m_done(d)) pm_stall[d] = pm_stall[d] + 32'd1;
`endif
                if (m_act[d]) begin
                    m_k[d] = m_k[d] + 1;
                    if (m_k[d] >= m_lat[d]) m_act[d] = 1'b0;
                    else if (m_done(d) && !m_store[d] && !m_fault[d]) e_wb[d] = m_rval[d];
                end else if (req_valid[d]) begin
                    m_act[d]   = 1'b1;
                    m_k[d]     = 0;
                    m_fault[d] = is_fault(req_addr[d], req_dm_ctrl[d]);
                    m_store[d] = req_mem_w[d];
                    m_lat[d]   = m_fault[d] ? 1 : (m_store[d] ? 2 : 2 + rl(d));
                    m_rval[d]  = rdata_val[d];
                    e_addr[d]  = req_addr[d];
                    e_ctrl[d]  = req_dm_ctrl[d];
                    e_wdata[d] = req_wdata[d];
                    if (m_fault[d]) e_fa[d] = req_addr[d];
                end
`ifdef MEM_STAGE_PERF_EN
                if (m_done(d) && !m_fault[d] && m_k[d] > 0) begin
                    if (m_store[d]) pm_stores[d] = pm_stores[d] + 32'd1;
                    else            pm_loads[d]  = pm_loads[d] + 32'd1;
                end
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                bit ed;
                bit een;
                ed  = m_done(d);
                een = m_act[d] && !m_fault[d] && (m_k[d] == 0);
                chk($sformatf("u%0d.dm_en", d),        32'(obs[d].dm_en),        32'(een));
                chk($sformatf("u%0d.dm_mem_w", d),     32'(obs[d].dm_mem_w),     32'(een && m_store[d]));
                chk($sformatf("u%0d.dm_addr", d),      obs[d].dm_addr,           e_addr[d]);
                chk($sformatf("u%0d.dm_ctrl", d),      32'(obs[d].dm_ctrl),      32'(e_ctrl[d]));
                chk($sformatf("u%0d.dm_wdata", d),     obs[d].dm_wdata,          e_wdata[d]);
                chk($sformatf("u%0d.stall", d),        32'(obs[d].stall),        32'(req_valid[d] && !ed));
                chk($sformatf("u%0d.done", d),         32'(obs[d].done),         32'(ed));
                chk($sformatf("u%0d.wb_valid", d),     32'(obs[d].wb_valid),     32'(ed && !m_store[d] && !m_fault[d]));
                chk($sformatf("u%0d.wb_rdata", d),     obs[d].wb_rdata,          e_wb[d]);
                chk($sformatf("u%0d.access_fault", d), 32'(obs[d].access_fault), 32'(ed && m_fault[d]));
                chk($sformatf("u%0d.fault_addr", d),   obs[d].fault_addr,        e_fa[d]);
            end
`ifdef MEM_STAGE_PERF_EN
            chk("u0.perf_loads",  perf_loads0,  pm_loads[0]);
            chk("u0.perf_stores", perf_stores0, pm_stores[0]);
            chk("u0.perf_stall",  perf_stall0,  pm_stall[0]);
            chk("u1.perf_loads",  perf_loads1,  pm_loads[1]);
            chk("u1.perf_stores", perf_stores1, pm_stores[1]);
            chk("u1.perf_stall",  perf_stall1,  pm_stall[1]);
`endif
        end
    end

    // Present one request just after a rising edge, hold it until done, then retire it
    task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] c, input bit drop_early,
                         output int lat, output int st, output int en, output int wbv, output int af);
        lat = -1; st = 0; en = 0; wbv = 0; af = 0;
        req_valid[d] = 1'b1; req_mem_w[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_dm_ctrl[d] = c;
        @(negedge clk);
        if (obs[d].stall) st++;
        @(posedge clk);
        #1;
        if (drop_early) req_valid[d] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (obs[d].stall) st++;
            if (obs[d].dm_en) en++;
            if (obs[d].wb_valid) wbv++;
            if (obs[d].access_fault) af++;
            if (obs[d].done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk($sformatf("u%0d.done_timeout", d), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, st, en, wbv, af;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_mem_w[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_dm_ctrl[d] = '0; rdata_val[d] = '0;
        end
        #3 rst = 1'b1;
        checking = 1'b1;
        @(posedge clk); #1;
        chk("rst.dm_en",      32'(obs[0].dm_en), 32'd0);
        chk("rst.done",       32'(obs[0].done),  32'd0);
        chk("rst.wb_rdata",   obs[0].wb_rdata,   32'd0);
        chk("rst.fault_addr", obs[0].fault_addr, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        rdata_val[0] = 32'hDEAD_BEEF;
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("lw.lat", 32'(lat), 32'd3);  chk("lw.stall", 32'(st), 32'd3);
        chk("lw.en", 32'(en), 32'd1);    chk("lw.wbv", 32'(wbv), 32'd1);
        chk("lw.wb_rdata", obs[0].wb_rdata, 32'hDEAD_BEEF);

        issue(0, 1'b1, 32'h13, 32'h0000_00A5, 3'b011, 1'b0, lat, st, en, wbv, af);
        chk("sb.lat", 32'(lat), 32'd2);  chk("sb.en", 32'(en), 32'd1);
        chk("sb.wbv", 32'(wbv), 32'd0);  chk("sb.addr", obs[0].dm_addr, 32'h13);
        chk("sb.ctrl", 32'(obs[0].dm_ctrl), 32'd3);
        chk("sb.wb_held", obs[0].wb_rdata, 32'hDEAD_BEEF);

        issue(0, 1'b0, 32'h21, 32'h0, 3'b001, 1'b0, lat, st, en, wbv, af);
        chk("lh_mis.lat", 32'(lat), 32'd1); chk("lh_mis.en", 32'(en), 32'd0);
        chk("lh_mis.af", 32'(af), 32'd1);   chk("lh_mis.fa", obs[0].fault_addr, 32'h21);

        issue(0, 1'b0, 32'h4000, 32'h0, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("lw_oor.lat", 32'(lat), 32'd1); chk("lw_oor.en", 32'(en), 32'd0);
        chk("lw_oor.fa", obs[0].fault_addr, 32'h4000);

        issue(0, 1'b0, 32'h30, 32'h0, 3'b111, 1'b0, lat, st, en, wbv, af);
        chk("ill.lat", 32'(lat), 32'd1); chk("ill.af", 32'(af), 32'd1);
        chk("ill.fa", obs[0].fault_addr, 32'h30);

        issue(0, 1'b1, 32'h102, 32'h5555_AAAA, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("sw_mis.lat", 32'(lat), 32'd1); chk("sw_mis.en", 32'(en), 32'd0);
        chk("sw_mis.fa", obs[0].fault_addr, 32'h102);

        rdata_val[0] = 32'h0000_BEEF;
        issue(0, 1'b0, 32'h22, 32'h0, 3'b010, 1'b0, lat, st, en, wbv, af);
        chk("lhu.lat", 32'(lat), 32'd3); chk("lhu.wb_rdata", obs[0].wb_rdata, 32'h0000_BEEF);

        rdata_val[0] = 32'h0000_00C3;
        issue(0, 1'b0, 32'h3FFF, 32'h0, 3'b100, 1'b0, lat, st, en, wbv, af);
        chk("lbu_top.lat", 32'(lat), 32'd3); chk("lbu_top.af", 32'(af), 32'd0);
        chk("lbu_top.wb_rdata", obs[0].wb_rdata, 32'h0000_00C3);

        rdata_val[0] = 32'h1234_5678;
        issue(0, 1'b0, 32'h44, 32'h0, 3'b000, 1'b1, lat, st, en, wbv, af);
        chk("lw_drop.lat", 32'(lat), 32'd3); chk("lw_drop.stall", 32'(st), 32'd1);
        chk("lw_drop.wb_rdata", obs[0].wb_rdata, 32'h1234_5678);

        rdata_val[1] = 32'h0000_005A;
        issue(1, 1'b0, 32'h42, 32'h0, 3'b100, 1'b0, lat, st, en, wbv, af);
        chk("rl3_lbu.lat", 32'(lat), 32'd5); chk("rl3_lbu.en", 32'(en), 32'd1);
        chk("rl3_lbu.stall", 32'(st), 32'd5);
        chk("rl3_lbu.addr", obs[1].dm_addr, 32'h42);
        chk("rl3_lbu.wb_rdata", obs[1].wb_rdata, 32'h0000_005A);
        issue(1, 1'b1, 32'h40, 32'hCAFE_F00D, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("rl3_sw.lat", 32'(lat), 32'd2);

        // reset lands in the ACCESS cycle of a store
        req_valid[0] = 1'b1; req_mem_w[0] = 1'b1; req_addr[0] = 32'h50;
        req_wdata[0] = 32'h1122_3344; req_dm_ctrl[0] = 3'b000;
        @(posedge clk); #1;
        chk("rst_mid.pre_en", 32'(obs[0].dm_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.en", 32'(obs[0].dm_en), 32'd0);
        chk("rst_mid.mem_w", 32'(obs[0].dm_mem_w), 32'd0);
        chk("rst_mid.addr", obs[0].dm_addr, 32'd0);
        chk("rst_mid.wdata", obs[0].dm_wdata, 32'd0);
        chk("rst_mid.wb_rdata", obs[0].wb_rdata, 32'd0);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        rdata_val[0] = 32'hA0A0_A0A0;
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("post_rst_lw.lat", 32'(lat), 32'd3);
        chk("post_rst_lw.wb_rdata", obs[0].wb_rdata, 32'hA0A0_A0A0);
        issue(0, 1'b1, 32'h20, 32'h0BAD_CAFE, 3'b000, 1'b0, lat, st, en, wbv, af);
        chk("post_rst_sw.lat", 32'(lat), 32'd2);
        issue(0, 1'b0, 32'h21, 32'h0, 3'b001, 1'b0, lat, st, en, wbv, af);
        chk("post_rst_lh.af", 32'(af), 32'd1);
`ifdef MEM_STAGE_PERF_EN
        chk("perf.loads",  perf_loads0,  32'd1);
        chk("perf.stores", perf_stores0, 32'd1);
        chk("perf.stall",  perf_stall0,  32'd6);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
